// File: rtl/input_conditioner.sv
// Player control conditioner: synchronises and debounces buttons/keyboard levels,
// arbitrates left/right moves (last press wins) and generates fire pulses with auto-repeat.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic       kb_left,
  input  logic       kb_right,
  input  logic       kb_fire,
  input  logic       enable,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_level,
  output logic       fire_pulse
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = (REPEAT_CYCLES > 0) ? RP_W'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} dir_t;
  typedef enum logic {F_IDLE, F_HELD} fire_t;

  // Channel order everywhere: [2]=left, [1]=right, [0]=fire
  logic [2:0] key_s1, key_s2;
  logic [2:0] kb_s1, kb_s2;
  logic [2:0] merged;

  logic [2:0][DB_W-1:0] db_cnt;
  logic [2:0]           stable;
  logic                 left_q, right_q;
  logic                 left_rise, right_rise;

  dir_t            dir, dir_next;
  fire_t           fstate;
  logic [RP_W-1:0] rpt_cnt;

  // Key synchronisers reset to the released (high) level so reset never looks like a press
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      kb_s1  <= '0;
      kb_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      kb_s1  <= {kb_left, kb_right, kb_fire};
      kb_s2  <= kb_s1;
    end
  end

  assign merged = ~key_s2 | kb_s2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= '0;
      db_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (merged[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= merged[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= stable[2];
      right_q <= stable[1];
    end
  end

  assign left_rise  = stable[2] & ~left_q;
  assign right_rise = stable[1] & ~right_q;

  always_comb begin
    dir_next = dir;
    if (!enable) begin
      dir_next = IDLE;
    end else begin
      case (dir)
        IDLE: begin
          if (stable[2] && !stable[1])      dir_next = LEFT;
          else if (stable[1] && !stable[2]) dir_next = RIGHT;
        end
        LEFT: begin
          if (!stable[2])     dir_next = stable[1] ? RIGHT : IDLE;
          else if (right_rise) dir_next = RIGHT;
        end
        RIGHT: begin
          if (!stable[1])     dir_next = stable[2] ? LEFT : IDLE;
          else if (left_rise) dir_next = LEFT;
        end
        default: dir_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir        <= IDLE;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      dir        <= dir_next;
      move_left  <= (dir_next == LEFT);
      move_right <= (dir_next == RIGHT);
    end
  end

  // Repeat counter reloads on every expiry, so pulses stay on a fixed grid even while disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fstate     <= F_IDLE;
      fire_pulse <= 1'b0;
      rpt_cnt    <= '0;
    end else begin
      fire_pulse <= 1'b0;
      case (fstate)
        F_IDLE: begin
          if (stable[0]) begin
            fstate     <= F_HELD;
            fire_pulse <= enable;
            rpt_cnt    <= RP_RELOAD;
          end
        end
        F_HELD: begin
          if (!stable[0]) begin
            fstate <= F_IDLE;
          end else if (REPEAT_CYCLES != 0) begin
            if (rpt_cnt == '0) begin
              fire_pulse <= enable;
              rpt_cnt    <= RP_RELOAD;
            end else begin
              rpt_cnt <= rpt_cnt - 1'b1;
            end
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  assign fire_level = stable[0];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a per-edge reference model pushes expected
// outputs, a negedge monitor pops and compares.
module tb_input_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RP = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] key_n;
  logic       kb_left, kb_right, kb_fire, enable;
  logic       move_left, move_right, fire_level, fire_pulse;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .key_n(key_n),
    .kb_left(kb_left),
    .kb_right(kb_right),
    .kb_fire(kb_fire),
    .enable(enable),
    .move_left(move_left),
    .move_right(move_right),
    .fire_level(fire_level),
    .fire_pulse(fire_pulse)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  // Reference model state: sampled levels, levels seen after synchronisation,
  // debounced levels, movement direction (0 none, 1 left, 2 right), fire hold start.
  bit [2:0] smp[$];
  bit [2:0] mq[$];
  bit [2:0] deb, deb_prev, mnow;
  int       dir;
  bit       fheld, pulse, flip;
  int       t0, edge_n;
  bit       L, R, F, Lr, Rr;

  always @(posedge clk) begin
    if (!resetn) begin
      smp.delete();
      mq.delete();
      deb = '0;
      deb_prev = '0;
      dir = 0;
      fheld = 0;
      t0 = 0;
      edge_n = 0;
      exp_q.push_back(4'b0000);
    end else begin
      edge_n++;
      smp.push_back({~key_n[2] | kb_left, ~key_n[1] | kb_right, ~key_n[0] | kb_fire});
      if (smp.size() > 3) void'(smp.pop_front());
      // A sample reaches the debouncer two edges after it is taken
      mnow = (smp.size() == 3) ? smp[0] : 3'b000;
      mq.push_back(mnow);
      if (mq.size() > DB) void'(mq.pop_front());

      L = deb[2]; R = deb[1]; F = deb[0];
      Lr = deb[2] & ~deb_prev[2];
      Rr = deb[1] & ~deb_prev[1];

      if (!enable)       dir = 0;
      else if (dir == 0) dir = (L && !R) ? 1 : ((R && !L) ? 2 : 0);
      else if (dir == 1) dir = !L ? (R ? 2 : 0) : (Rr ? 2 : 1);
      else               dir = !R ? (L ? 1 : 0) : (Lr ? 1 : 2);

      pulse = 0;
      if (!fheld) begin
        if (F) begin
          fheld = 1;
          t0 = edge_n;
          pulse = enable;
        end
      end else if (!F) begin
        fheld = 0;
      end else if (RP > 0 && ((edge_n - t0) % RP) == 0) begin
        pulse = enable;
      end

      deb_prev = deb;
      // Debounced level flips once the last DB post-sync samples all disagree with it
      for (int ch = 0; ch < 3; ch++) begin
        flip = (mq.size() == DB);
        for (int k = 0; k < DB; k++)
          if (k < mq.size() && mq[k][ch] == deb[ch]) flip = 0;
        if (flip) deb[ch] = ~deb[ch];
      end

      exp_q.push_back({dir == 1, dir == 2, deb[0], pulse});
    end
  end

  logic [3:0] expv;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      vectors++;
      if ({move_left, move_right, fire_level, fire_pulse} !== expv) begin
        miscompares++;
        $display("FAIL outputs t=%0t {ml,mr,fl,fp} got %b expected %b",
                 $time, {move_left, move_right, fire_level, fire_pulse}, expv);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_n = 3'b111;
    kb_left = 0;
    kb_right = 0;
    kb_fire = 0;
  endtask

  // Reset asserted between edges must clear the outputs at once
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2 resetn = 0;
    #1;
    vectors++;
    if ({move_left, move_right, fire_level, fire_pulse} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset got %b expected 0000",
               {move_left, move_right, fire_level, fire_pulse});
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1;
    step(1);
  endtask

  initial begin
    resetn = 0;
    key_n = 3'b000;
    kb_left = 1; kb_right = 1; kb_fire = 1;
    enable = 1;
    step(5);
    idle_inputs();
    @(negedge clk);
    #2 resetn = 1;
    step(20);

    // debounce latency, then a short glitch that must be rejected
    key_n[2] = 0; step(14);
    key_n[2] = 1; step(10);
    key_n[1] = 0; step(3);
    key_n[1] = 1; step(12);

    // last press wins, release back to left, simultaneous press
    key_n[2] = 0; step(10);
    kb_right = 1; step(10);
    kb_right = 0; step(10);
    key_n[2] = 1; step(10);
    kb_left = 1; key_n[1] = 0; step(12);
    idle_inputs(); step(10);

    // fire repeat and release
    kb_fire = 1; step(36);
    kb_fire = 0; step(14);

    // enable gating while left and fire are held
    enable = 0;
    key_n[2] = 0; key_n[0] = 0; step(20);
    enable = 1; step(20);
    idle_inputs(); step(10);

    // async reset mid-press, released with fire still held
    kb_fire = 1; step(15);
    async_reset(3);
    step(25);
    kb_fire = 0; step(12);

    // randomised traffic, including button/keyboard overlap and enable toggling
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) key_n[b] = ~key_n[b];
      if ($urandom_range(0, 5) == 0) kb_left = ~kb_left;
      if ($urandom_range(0, 5) == 0) kb_right = ~kb_right;
      if ($urandom_range(0, 7) == 0) kb_fire = ~kb_fire;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ((c % 700) == 350) async_reset($urandom_range(1, 3));
      else step($urandom_range(1, 3));
    end
    idle_inputs(); step(12);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
